// File: rtl/reg_file_master.sv
// reg_file_master: serial bus initiator for the register-file WR_EN/RD_EN/DIN/DOUT port.
// Parallel requests come in on a valid/ready port and are shifted out MSB first.
module reg_file_master #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  REQ_VALID,
    output logic                  REQ_READY,
    input  logic                  REQ_WRITE,
    input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
    input  logic [DATA_WIDTH-1:0] REQ_WDATA,
    output logic                  RSP_VALID,
    output logic [DATA_WIDTH-1:0] RSP_RDATA,
    output logic                  BUSY,
    output logic                  WR_EN,
    output logic                  RD_EN,
    output logic                  DIN,
    input  logic                  DOUT
);
    localparam int MAX_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CW    = $clog2(MAX_W + 1);

    typedef enum logic [2:0] {
        IDLE,
        STROBE,
        ADDR,
        WDATA,
        TURN,
        RDATA
    } state_t;

    state_t                  state_q;
    logic [CW-1:0]           cnt_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    write_q;
    logic                    ready_q;
    logic                    busy_q;
    logic                    wr_en_q;
    logic                    rd_en_q;
    logic                    din_q;
    logic                    rsp_valid_q;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q;

    logic                    accept;
    logic                    last_bit;
    logic                    data_st;
    logic                    to_addr;
    logic [CW-1:0]           cnt_dec_d;
    logic [DATA_WIDTH-1:0]   rd_shift_d;

    assign accept     = REQ_VALID && ready_q;
    assign last_bit   = (cnt_q == '0);
    assign data_st    = (state_q == WDATA) || (state_q == RDATA);
    assign cnt_dec_d  = cnt_q - CW'(1);
    assign rd_shift_d = (rdata_q << 1) | DATA_WIDTH'(DOUT);
    // A strobe already on the bus during the last data bit means the next
    // transaction is overlapped: skip straight to its address phase.
    assign to_addr    = (state_q == STROBE) || (data_st && last_bit && (wr_en_q || rd_en_q));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            write_q     <= 1'b0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            din_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;

            if (state_q == RDATA) begin
                rdata_q <= rd_shift_d;
                if (last_bit) begin
                    rsp_valid_q <= 1'b1;
                    rsp_rdata_q <= rd_shift_d;
                end
            end

            if (to_addr) begin
                state_q <= ADDR;
                cnt_q   <= CW'(ADDR_WIDTH - 1);
                din_q   <= addr_q[ADDR_WIDTH-1];
                addr_q  <= addr_q << 1;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (accept) begin
                            state_q <= STROBE;
                            din_q   <= 1'b0;
                        end
                    end
                    ADDR: begin
                        if (!last_bit) begin
                            cnt_q  <= cnt_dec_d;
                            din_q  <= addr_q[ADDR_WIDTH-1];
                            addr_q <= addr_q << 1;
                        end else if (write_q) begin
                            state_q <= WDATA;
                            cnt_q   <= CW'(DATA_WIDTH - 1);
                            din_q   <= wdata_q[DATA_WIDTH-1];
                            wdata_q <= wdata_q << 1;
                            ready_q <= (DATA_WIDTH == 2);
                        end else begin
                            state_q <= TURN;
                            din_q   <= 1'b0;
                        end
                    end
                    TURN: begin
                        state_q <= RDATA;
                        cnt_q   <= CW'(DATA_WIDTH - 1);
                        din_q   <= 1'b0;
                        ready_q <= (DATA_WIDTH == 2);
                    end
                    WDATA, RDATA: begin
                        if (!last_bit) begin
                            cnt_q   <= cnt_dec_d;
                            ready_q <= (cnt_q == CW'(2));
                            if (state_q == WDATA) begin
                                din_q   <= wdata_q[DATA_WIDTH-1];
                                wdata_q <= wdata_q << 1;
                            end else begin
                                din_q   <= 1'b0;
                            end
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            ready_q <= 1'b1;
                            din_q   <= 1'b0;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end

            // Placed last so a newly accepted request overrides the shift updates.
            if (accept) begin
                addr_q  <= REQ_ADDR;
                wdata_q <= REQ_WDATA;
                write_q <= REQ_WRITE;
                wr_en_q <= REQ_WRITE;
                rd_en_q <= !REQ_WRITE;
                ready_q <= 1'b0;
                busy_q  <= 1'b1;
            end
        end
    end

    assign REQ_READY = ready_q;
    assign BUSY      = busy_q;
    assign WR_EN     = wr_en_q;
    assign RD_EN     = rd_en_q;
    assign DIN       = din_q;
    assign RSP_VALID = rsp_valid_q;
    assign RSP_RDATA = rsp_rdata_q;

endmodule

// File: tb/tb_reg_file_master.sv
// Bench for reg_file_master: directed requests, a serial slave model that decodes
// the bus, and scoreboards for decoded transactions and read responses.
module tb_reg_file_master;
    logic       CLK = 1'b0;
    logic       RST;
    logic       REQ_VALID;
    logic       REQ_READY;
    logic       REQ_WRITE;
    logic [7:0] REQ_ADDR;
    logic [7:0] REQ_WDATA;
    logic       RSP_VALID;
    logic [7:0] RSP_RDATA;
    logic       BUSY;
    logic       WR_EN;
    logic       RD_EN;
    logic       DIN;
    logic       DOUT = 1'b0;

    reg_file_master #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
        .CLK(CLK), .RST(RST),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WRITE(REQ_WRITE),
        .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
        .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .BUSY(BUSY),
        .WR_EN(WR_EN), .RD_EN(RD_EN), .DIN(DIN), .DOUT(DOUT)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    logic [16:0] exp_txn [$];
    logic [7:0]  exp_rsp [$];
    int          rsp_cyc [$];
    int          rsp_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Slave model: unwritten registers return a fixed scramble of the address.
    bit [7:0] mem     [256];
    bit       mem_vld [256];
    int       m_ph  = 0;
    int       m_cnt = 0;
    logic       m_wr;
    logic [7:0] m_addr, m_data, m_rd;

    function automatic logic [7:0] rd_val(input logic [7:0] a);
        if (mem_vld[a]) return mem[a];
        return {a[3:0], a[7:4]} ^ 8'h66;
    endfunction

    always @(negedge CLK) begin
        int prev_ph;
        if (RST) begin
            m_ph  = 0;
            m_cnt = 0;
            DOUT  = 1'b0;
        end else begin
            prev_ph = m_ph;
            DOUT = 1'b0;
            case (m_ph)
                0: if (!WR_EN && !RD_EN) check("idle_din", DIN, 0);
                1: begin
                    m_addr = {m_addr[6:0], DIN};
                    m_cnt++;
                    if (m_cnt == 8) begin
                        m_cnt = 0;
                        if (m_wr) m_ph = 2;
                        else begin
                            m_ph = 3;
                            if (exp_txn.size() == 0) check("txn_unexpected", exp_txn.size(), 1);
                            else check("rd_txn", {1'b0, m_addr, 8'h00}, exp_txn.pop_front());
                        end
                    end
                end
                2: begin
                    m_data = {m_data[6:0], DIN};
                    m_cnt++;
                    if (m_cnt == 8) begin
                        m_cnt = 0;
                        m_ph = 0;
                        mem[m_addr] = m_data;
                        mem_vld[m_addr] = 1'b1;
                        if (exp_txn.size() == 0) check("txn_unexpected", exp_txn.size(), 1);
                        else check("wr_txn", {1'b1, m_addr, m_data}, exp_txn.pop_front());
                    end
                end
                3: begin
                    check("turn_din", DIN, 0);
                    m_rd = rd_val(m_addr);
                    m_ph = 4;
                end
                default: begin
                    check("rdata_din", DIN, 0);
                    DOUT = m_rd[7 - m_cnt];
                    m_cnt++;
                    if (m_cnt == 8) begin
                        m_cnt = 0;
                        m_ph = 0;
                    end
                end
            endcase
            if (WR_EN || RD_EN) begin
                check("strobe_onehot", WR_EN ^ RD_EN, 1);
                check("strobe_phase", m_ph, 0);
                if (prev_ph == 0) check("strobe_din", DIN, 0);
                m_wr   = WR_EN;
                m_ph   = 1;
                m_cnt  = 0;
                m_addr = 8'h00;
            end
        end
    end

    always @(negedge CLK) begin
        if (!RST && RSP_VALID) begin
            rsp_cnt++;
            rsp_cyc.push_back(cyc);
            if (exp_rsp.size() == 0) check("rsp_unexpected", exp_rsp.size(), 1);
            else check("rsp_data", RSP_RDATA, exp_rsp.pop_front());
        end
    end

    // Call just after a negedge; returns at the negedge of the strobe cycle C0.
    task automatic issue(input bit wr, input logic [7:0] a, input logic [7:0] d,
                         input logic [7:0] rexp, input bit keep, output int acc, output int lows);
        int n;
        n = 0;
        lows = 0;
        REQ_VALID = 1'b1;
        REQ_WRITE = wr;
        REQ_ADDR  = a;
        REQ_WDATA = d;
        while (!REQ_READY && n < 100) begin
            if (!BUSY) lows++;
            @(negedge CLK);
            n++;
        end
        if (!REQ_READY) begin
            check("accept_timeout", REQ_READY, 1);
            REQ_VALID = 1'b0;
            acc = -1;
            return;
        end
        if (!BUSY) lows++;
        acc = cyc + 1;
        exp_txn.push_back({wr, a, wr ? d : 8'h00});
        if (!wr) exp_rsp.push_back(rexp);
        @(negedge CLK);
        if (!keep) REQ_VALID = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(REQ_READY && !BUSY) && n < 100) begin
            @(negedge CLK);
            n++;
        end
        check("idle_timeout", REQ_READY && !BUSY, 1);
        repeat (2) @(negedge CLK);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a1, a2, a3, a4, lo, base, rel;
        logic [16:0] dv;
        RST = 1'b1;
        REQ_VALID = 1'b0;
        REQ_WRITE = 1'b0;
        REQ_ADDR  = 8'h00;
        REQ_WDATA = 8'h00;
        repeat (3) @(negedge CLK);
        check("rst_ready", REQ_READY, 1);
        check("rst_busy", BUSY, 0);
        check("rst_wr_en", WR_EN, 0);
        check("rst_rd_en", RD_EN, 0);
        check("rst_din", DIN, 0);
        check("rst_rsp_valid", RSP_VALID, 0);
        check("rst_rsp_rdata", RSP_RDATA, 0);
        RST = 1'b0;
        @(negedge CLK);

        // Write 0x34 <- 0xFF from idle
        issue(1'b1, 8'h34, 8'hFF, 8'h00, 1'b0, a1, lo);
        check("w_wr_en_c0", WR_EN, 1);
        check("w_rd_en_c0", RD_EN, 0);
        check("w_din_c0", DIN, 0);
        check("w_busy_c0", BUSY, 1);
        check("w_ready_c0", REQ_READY, 0);
        dv = '0;
        for (int k = 1; k <= 17; k++) begin
            @(negedge CLK);
            dv = {dv[15:0], DIN};
            if (k == 1) check("w_wr_en_c1", WR_EN, 0);
            if (k == 15) check("w_ready_c15", REQ_READY, 1);
            if (k == 16) begin
                check("w_ready_c16", REQ_READY, 0);
                check("w_busy_c16", BUSY, 1);
            end
            if (k == 17) begin
                check("w_ready_c17", REQ_READY, 1);
                check("w_busy_c17", BUSY, 0);
            end
        end
        check("w_din_seq", dv, {8'h34, 8'hFF, 1'b0});

        // Read 0x55, slave returns 0x33
        issue(1'b0, 8'h55, 8'h00, 8'h33, 1'b0, a1, lo);
        check("r_rd_en_c0", RD_EN, 1);
        check("r_wr_en_c0", WR_EN, 0);
        dv = '0;
        for (int k = 1; k <= 19; k++) begin
            @(negedge CLK);
            if (k <= 9) dv = {dv[15:0], DIN};
            if (k == 1) check("r_rd_en_c1", RD_EN, 0);
            if (k == 16) check("r_ready_c16", REQ_READY, 1);
            if (k == 17) begin
                check("r_ready_c17", REQ_READY, 0);
                check("r_rsp_c17", RSP_VALID, 0);
            end
            if (k == 18) begin
                check("r_rsp_c18", RSP_VALID, 1);
                check("r_rdata_c18", RSP_RDATA, 8'h33);
            end
            if (k == 19) begin
                check("r_rsp_c19", RSP_VALID, 0);
                check("r_rdata_hold", RSP_RDATA, 8'h33);
            end
        end
        check("r_din_seq", dv[8:0], {8'h55, 1'b0});

        // Back-to-back writes with REQ_VALID held
        issue(1'b1, 8'h34, 8'hDD, 8'h00, 1'b1, a1, lo);
        issue(1'b1, 8'h78, 8'h81, 8'h00, 1'b0, a2, lo);
        check("b2b_gap", a2 - a1, 16);
        check("b2b_busy_gap", lo, 0);
        check("b2b_wr_en", WR_EN, 1);
        check("b2b_din_overlap", DIN, 1);
        dv = '0;
        lo = 0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge CLK);
            dv = {dv[15:0], DIN};
            if (!BUSY) lo++;
        end
        check("b2b_din_seq", dv[15:0], 16'h7881);
        check("b2b_busy", lo, 0);
        wait_idle();
        check("rdata_hold_writes", RSP_RDATA, 8'h33);

        // Write, overlapped read, then back-to-back reads
        rsp_cyc.delete();
        issue(1'b1, 8'hA1, 8'hDD, 8'h00, 1'b1, a1, lo);
        issue(1'b0, 8'h06, 8'h00, 8'h06, 1'b1, a2, lo);
        check("mix_gap_wr", a2 - a1, 16);
        check("mix_rd_en", RD_EN, 1);
        check("mix_wr_en", WR_EN, 0);
        check("mix_din_overlap", DIN, 1);
        issue(1'b0, 8'h34, 8'h00, 8'hDD, 1'b1, a3, lo);
        check("mix_gap_rd1", a3 - a2, 17);
        check("mix_rd_en2", RD_EN, 1);
        check("mix_din_rd", DIN, 0);
        issue(1'b0, 8'h78, 8'h00, 8'h81, 1'b0, a4, lo);
        check("mix_gap_rd2", a4 - a3, 17);
        wait_idle();
        check("mix_rsp_count", rsp_cyc.size(), 3);
        if (rsp_cyc.size() == 3) begin
            check("mix_rsp0_cyc", rsp_cyc[0], a2 + 18);
            check("mix_rsp1_cyc", rsp_cyc[1], a3 + 18);
            check("mix_rsp2_cyc", rsp_cyc[2], a4 + 18);
            check("mix_rsp_spacing", rsp_cyc[2] - rsp_cyc[1], 17);
        end

        // REQ_VALID held through a read while the request fields wander
        issue(1'b0, 8'h55, 8'h00, 8'h33, 1'b1, a1, lo);
        for (int k = 1; k <= 16; k++) begin
            @(negedge CLK);
            REQ_WRITE = k[0];
            REQ_ADDR  = 8'(k * 37);
            REQ_WDATA = 8'(k * 11);
            check("hold_ready", REQ_READY, (k == 16));
        end
        REQ_WRITE = 1'b1;
        REQ_ADDR  = 8'hC3;
        REQ_WDATA = 8'h3C;
        exp_txn.push_back({1'b1, 8'hC3, 8'h3C});
        @(negedge CLK);
        REQ_VALID = 1'b0;
        check("hold_wr_en", WR_EN, 1);
        check("hold_ready_c17", REQ_READY, 0);
        wait_idle();

        // Reset in C5 of a read
        base = rsp_cnt;
        issue(1'b0, 8'h55, 8'h00, 8'h33, 1'b0, a1, lo);
        repeat (5) @(negedge CLK);
        RST = 1'b1;
        void'(exp_txn.pop_back());
        void'(exp_rsp.pop_back());
        #1;
        check("mid_rst_ready", REQ_READY, 1);
        check("mid_rst_busy", BUSY, 0);
        check("mid_rst_wr_en", WR_EN, 0);
        check("mid_rst_rd_en", RD_EN, 0);
        check("mid_rst_din", DIN, 0);
        check("mid_rst_rsp_valid", RSP_VALID, 0);
        check("mid_rst_rsp_rdata", RSP_RDATA, 0);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        rel = cyc;
        issue(1'b1, 8'h12, 8'h34, 8'h00, 1'b0, a2, lo);
        check("rst_accept", a2, rel + 1);
        wait_idle();
        repeat (20) @(negedge CLK);
        check("rst_no_rsp", rsp_cnt, base);
        check("rst_rsp_q", exp_rsp.size(), 0);
        check("txn_q_empty", exp_txn.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
